// File: rtl/lc3_decode_pkg.sv
// LC-3 decode stage shared definitions: opcodes, control-field encodings,
// the decode bundle carried through the skid buffer, and the instruction
// decoder itself.
package lc3_decode_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_NONE = 2'b00;
    localparam logic [1:0] PCSEL1_OFF6 = 2'b01;
    localparam logic [1:0] PCSEL1_OFF9 = 2'b10;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_LEA = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;

    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [ADDR_W-1:0]  npc;
        logic [5:0]         e_ctl;
        logic [1:0]         w_ctl;
        logic               mem_ctl;
    } decode_bundle_t;

    typedef struct packed {
        logic [5:0] e_ctl;
        logic [1:0] w_ctl;
        logic       mem_ctl;
    } decode_ctl_t;

    // E control layout is {alu_ctl, pcsel1, pcsel2, op2sel}; anything not
    // listed (JSR, RTI, reserved, TRAP) and JMP keep every field at zero.
    function automatic decode_ctl_t decode_instr(input logic [INSTR_W-1:0] ir);
        decode_ctl_t c;
        logic [1:0]  alu;
        logic [1:0]  pcsel1;
        logic        pcsel2;
        logic        op2sel;
        alu       = ALU_ADD;
        pcsel1    = PCSEL1_NONE;
        pcsel2    = 1'b0;
        op2sel    = 1'b0;
        c.w_ctl   = WSEL_ALU;
        c.mem_ctl = 1'b0;
        case (opcode_e'(ir[15:12]))
            OP_ADD: begin alu = ALU_ADD; op2sel = ~ir[5]; end
            OP_AND: begin alu = ALU_AND; op2sel = ~ir[5]; end
            OP_NOT: begin alu = ALU_NOT; op2sel = 1'b1; end
            OP_BR, OP_ST: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; end
            OP_LD: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; c.w_ctl = WSEL_MEM; end
            OP_LDI: begin
                pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1;
                c.w_ctl = WSEL_MEM; c.mem_ctl = 1'b1;
            end
            OP_STI: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; c.mem_ctl = 1'b1; end
            OP_LEA: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; c.w_ctl = WSEL_LEA; end
            OP_LDR: begin pcsel1 = PCSEL1_OFF6; c.w_ctl = WSEL_MEM; end
            OP_STR: begin pcsel1 = PCSEL1_OFF6; end
            default: ;
        endcase
        c.e_ctl = {alu, pcsel1, pcsel2, op2sel};
        return c;
    endfunction

    // Opcodes this stage does not implement.
    function automatic logic is_legal(input logic [3:0] op);
        return !(op == OP_JSR || op == OP_RTI || op == OP_RES || op == OP_TRAP);
    endfunction

endpackage

// File: rtl/lc3_skid_buffer.sv
// Two-entry valid/ready buffer for decode bundles. The head register drives
// the outputs directly; the skid register catches the one extra item that can
// arrive while the consumer is stalled, so nothing is ever dropped.
module lc3_skid_buffer
    import lc3_decode_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  decode_bundle_t in_data_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output decode_bundle_t out_data_o
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e         state_q, state_d;
    decode_bundle_t head_q, head_d;
    decode_bundle_t skid_q, skid_d;
    logic           accept;
    logic           pop;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Occupancy transitions; flush empties the buffer but leaves data alone.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    head_d  = in_data_i;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers, cleared to an empty all-zero buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 pipeline decode stage: decodes the fetched instruction into execute,
// memory and writeback controls and hands the bundle to execute through a
// valid/ready skid buffer.
// Optional: LC3_DECODE_ILLEGAL_TRAP_EN drops unsupported opcodes after the
// handshake and counts them on illegal_cnt (saturating at 255).
module lc3_decode_stage
    import lc3_decode_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr_dout,
    input  logic [AW-1:0] npc_in,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
    output logic [7:0]    illegal_cnt,
`endif
    output logic [IW-1:0] ir_out,
    output logic [AW-1:0] npc_out,
    output logic [5:0]    E_control,
    output logic [1:0]    W_control,
    output logic          Mem_control
);

    decode_ctl_t    ctl;
    decode_bundle_t inBundle;
    decode_bundle_t outBundle;
    logic           enqValid;

    // Decode the incoming instruction and pack it with its NPC.
    always_comb begin
        ctl              = decode_instr(instr_dout);
        inBundle.ir      = instr_dout;
        inBundle.npc     = npc_in;
        inBundle.e_ctl   = ctl.e_ctl;
        inBundle.w_ctl   = ctl.w_ctl;
        inBundle.mem_ctl = ctl.mem_ctl;
    end

`ifdef LC3_DECODE_ILLEGAL_TRAP_EN
    logic       legal;
    logic       illegalAccept;
    logic [7:0] illegalCnt_q, illegalCnt_d;

    assign legal         = is_legal(instr_dout[15:12]);
    assign enqValid      = in_valid & legal;
    assign illegalAccept = in_valid & in_ready & ~legal;
    assign illegal_cnt   = illegalCnt_q;

    // Saturating count of consumed-but-dropped unsupported instructions.
    always_comb begin
        illegalCnt_d = illegalCnt_q;
        if (illegalAccept && illegalCnt_q != 8'hFF) begin
            illegalCnt_d = illegalCnt_q + 8'd1;
        end
    end

    // Counter register; flush deliberately does not clear it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegalCnt_q <= '0;
        end else begin
            illegalCnt_q <= illegalCnt_d;
        end
    end
`else
    assign enqValid = in_valid;
`endif

    lc3_skid_buffer u_skid (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (enqValid),
        .in_ready_o  (in_ready),
        .in_data_i   (inBundle),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (outBundle)
    );

    assign ir_out      = outBundle.ir;
    assign npc_out     = outBundle.npc;
    assign E_control   = outBundle.e_ctl;
    assign W_control   = outBundle.w_ctl;
    assign Mem_control = outBundle.mem_ctl;

endmodule

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
- LC-3 pipeline decode stage. Drives the decode-output bundle: W_control, Mem_control, E_control, the registered instruction and the registered NPC.
- Fetch/instruction memory feeds it; execute consumes it.
- Replaces free-running enable-gated latching with a valid/ready handshake and a 2-entry skid buffer, so execute back-pressure never drops an instruction.

Parameters:
- IW, 16, instruction width
- AW, 16, NPC/address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  instr_dout/npc_in valid
- in_ready  out  1  stage can accept
- instr_dout  in  IW  fetched instruction
- npc_in  in  AW  PC+1 of fetched instruction
- out_valid  out  1  decode bundle valid
- out_ready  in  1  execute accepts bundle
- ir_out  out  IW  registered instruction
- npc_out  out  AW  registered NPC
- E_control  out  6  {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}
- W_control  out  2  writeback select
- Mem_control  out  1  1 = indirect memory access

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-high, named reset.
- Reset values: out_valid=0, in_ready=1, all data/control outputs 0, skid empty.
- Decode (combinational on instr_dout[15:12], registered with the payload):
  - ADD 0001 / AND 0101 / NOT 1001:
    - alu_ctl = 00 / 01 / 10
    - pcsel1 = 00, pcsel2 = 0
    - op2sel = ~IR[5] for ADD/AND; op2sel = 1 for NOT
    - W=00
  - BR 0000, LD 0010, ST 0011, LDI 1010, STI 1011, LEA 1110: pcsel1=10 (offset9), pcsel2=1 (NPC).
  - LDR 0110, STR 0111: pcsel1=01 (offset6), pcsel2=0 (base reg).
  - JMP 1100: pcsel1=00, pcsel2=0.
  - W_control: 10 for LD/LDR/LDI, 01 for LEA, 00 otherwise.
  - Mem_control = 1 only for LDI/STI.
  - All non-ALU opcodes: alu_ctl=00, op2sel=0.
  - Unsupported opcodes (0100, 1000, 1101, 1111): all control fields 0.
- Buffer FSM, states EMPTY, ONE, FULL:
  - The output register is the head; the skid register is the second entry.
  - Latency: 1 cycle from accepted input to out_valid.
  - in_ready = ~FULL, registered.
  - Accept iff in_valid & in_ready. Pop iff out_valid & out_ready.
  - EMPTY, accept → ONE.
  - ONE, accept & pop → ONE; the head is replaced.
  - ONE, accept & no pop → FULL; the new entry goes to skid.
  - ONE, pop & no accept → EMPTY.
  - FULL, pop → ONE; skid moves to head.
  - FULL: no accept possible.
- Output stability: the bundle stays stable while out_valid & ~out_ready.
- flush: synchronous; priority over accept and pop. Next state EMPTY, out_valid=0; data outputs keep their values.
- reset mid-operation: immediate return to reset values; buffered entries discarded.

Optional Feature:
- Macro: LC3_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcodes are accepted (in_ready handshake honoured) but never enqueued.
  - Output port illegal_cnt [7:0] counts them, saturating at 255, reset 0, unaffected by flush.
- Undefined:
  - Unsupported opcodes pass through with zero controls.
  - Port illegal_cnt is absent.

Decomposition:
- Package lc3_decode_pkg holds:
  - opcode enum
  - alu_ctl, pcsel1 and W-select localparams
  - packed struct decode_bundle_t {ir, npc, e_ctl, w_ctl, mem_ctl}
  - function decode_instr(ir) returning the control fields
- One sub-module: lc3_skid_buffer, a generic 2-entry valid/ready buffer on decode_bundle_t.

Test Plan:
- Reset pulse mid-stream with FULL buffer:
  - required: out_valid=0, in_ready=1, all outputs 0 on the same cycle.
- in_valid=1, instr_dout=16'h1283 (ADD R1,R2,R3), npc_in=16'h3001, out_ready=1:
  - required next cycle: E_control=6'b000001, W_control=00, Mem_control=0, npc_out=3001.
- LDI 16'hA5FF then LEA 16'hE205, back to back:
  - LDI: E_control=6'b001010, W=10, Mem=1.
  - LEA: E_control=6'b001010, W=01, Mem=0.
- out_ready=0, three consecutive in_valid instructions A,B,C:
  - A held on outputs, B in skid, in_ready=0 after 2 accepts, C stalled.
  - Release out_ready: A, B, C delivered in order, none lost or duplicated.
- FULL buffer, flush=1 with in_valid=1 in the same cycle:
  - required next cycle: out_valid=0, in_ready=1, the flush-cycle input not captured.
- With the macro defined, opcode 1101 sent 300 times:
  - required: no out_valid; illegal_cnt saturates at 255.
- Without the macro, opcode 1101 sent:
  - required: out_valid=1 with E/W/Mem=0.
